// File: rtl/scene_pkg.sv
// Scene codes and key constants shared by the sequencer, the sprite stages and the color mapper.
package scene_pkg;

    typedef enum logic [3:0] {
        ST_TITLE        = 4'd0,
        ST_ROOM         = 4'd2,
        ST_BATTLE_MENU  = 4'd3,
        ST_BATTLE_DODGE = 4'd4,
        ST_FLOWER       = 4'd5,
        ST_GAMEOVER     = 4'd6,
        ST_WIN          = 4'd7
    } status_t;

    localparam logic [7:0]  KEY_NONE      = 8'h00;
    localparam logic [7:0]  KEY_ENTER     = 8'h28;
    localparam logic [11:0] FRAME_CNT_MAX = 12'hFFF;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain as a one-cycle tick per rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       dly_q, dly_d;
    logic [1:0] fill_q, fill_d;

    always_comb begin
        sync1_d = frame_clk;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            fill_q  <= 2'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
            fill_q  <= fill_d;
        end
    end

    // Edges are only trusted once the whole chain holds sampled data, so a strobe
    // that is already high at reset release is not mistaken for a new frame.
    assign tick = sync2_q & ~dly_q & (fill_q == 2'd3);

endmodule

// File: rtl/scene_sequencer.sv
// Game-flow FSM: drives the scene status code, per-scene frame count and a scene-start pulse.
module scene_sequencer
    import scene_pkg::*;
#(
    parameter int unsigned FLOWER_FRAMES = 360,
    parameter int unsigned GAMEOVER_LOCK = 60,
    parameter logic [7:0]  CONFIRM_KEY   = KEY_ENTER
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic        encounter,
    input  logic        dodge_done,
    input  logic        enemy_defeated,
    input  logic [7:0]  player_hp,
    output logic [3:0]  status,
    output logic [11:0] frame_cnt,
    output logic        scene_start
);

    logic        tick;
    logic        confirm;
    logic        trans;
    logic [3:0]  status_q, status_d;
    logic [11:0] frame_cnt_q, frame_cnt_d;
    logic        scene_start_q, scene_start_d;
    logic [7:0]  key_prev_q, key_prev_d;
    logic        key_armed_q, key_armed_d;

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // A key held through reset must be released once before it can confirm.
    assign confirm = (keycode == CONFIRM_KEY) && (key_prev_q != CONFIRM_KEY) && key_armed_q;

    always_comb begin
        status_d = status_q;
        case (status_q)
            ST_TITLE:        if (confirm) status_d = ST_ROOM;
            ST_ROOM:         if (encounter) status_d = ST_FLOWER;
            ST_FLOWER:       if (tick && frame_cnt_q == 12'(FLOWER_FRAMES - 1)) status_d = ST_BATTLE_MENU;
            ST_BATTLE_MENU:  if (confirm) status_d = ST_BATTLE_DODGE;
            ST_BATTLE_DODGE: begin
                if (player_hp == 8'd0)                status_d = ST_GAMEOVER;
                else if (dodge_done && enemy_defeated) status_d = ST_WIN;
                else if (dodge_done)                   status_d = ST_BATTLE_MENU;
            end
            ST_GAMEOVER:     if (confirm && frame_cnt_q >= 12'(GAMEOVER_LOCK)) status_d = ST_TITLE;
            ST_WIN:          if (confirm) status_d = ST_TITLE;
            default:         status_d = ST_TITLE;
        endcase
    end

    always_comb begin
        trans         = (status_d != status_q);
        scene_start_d = trans;
        key_prev_d    = keycode;
        key_armed_d   = key_armed_q | (keycode != CONFIRM_KEY);
        if (trans)
            frame_cnt_d = 12'd0;
        else if (tick && frame_cnt_q != FRAME_CNT_MAX)
            frame_cnt_d = frame_cnt_q + 12'd1;
        else
            frame_cnt_d = frame_cnt_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            status_q      <= ST_TITLE;
            frame_cnt_q   <= 12'd0;
            scene_start_q <= 1'b0;
            key_prev_q    <= KEY_NONE;
            key_armed_q   <= 1'b0;
        end else begin
            status_q      <= status_d;
            frame_cnt_q   <= frame_cnt_d;
            scene_start_q <= scene_start_d;
            key_prev_q    <= key_prev_d;
            key_armed_q   <= key_armed_d;
        end
    end

    assign status      = status_q;
    assign frame_cnt   = frame_cnt_q;
    assign scene_start = scene_start_q;

endmodule

// File: doc/scene_sequencer.md
# scene_sequencer

Top-level game-flow controller that produces the 4-bit `status` code consumed by every sprite stage: title, room, flower cutscene, battle, game over, win. It synchronises `frame_clk` into the `Clk` domain and counts frames per scene. It also sequences scene changes from keyboard presses and battle events. The flower cutscene (status 5) is held for a fixed number of frames, so the flower animation's 1/120/240-frame steps always play out in full.

## Interface
Parameters:
- `FLOWER_FRAMES`, 360: frames spent in status 5 before the battle menu.
- `GAMEOVER_LOCK`, 60: frames after entering GAMEOVER during which confirm is ignored.
- `CONFIRM_KEY`, 8'h28: USB HID code of the confirm key (Enter).

Ports:
- `Clk`, input, 1: system clock. One clock domain only.
- `Reset`, input, 1: asynchronous, active-high reset.
- `frame_clk`, input, 1: vertical-sync-rate strobe. Asynchronous to `Clk`. Rising edge marks one frame.
- `keycode`, input, 8: current keyboard code. 0 means no key.
- `encounter`, input, 1: level; room logic requests the flower cutscene.
- `dodge_done`, input, 1: level; the enemy attack phase has finished.
- `enemy_defeated`, input, 1: level; enemy HP is zero.
- `player_hp`, input, 8: current player HP.
- `status`, output, 4: scene code, registered.
- `frame_cnt`, output, 12: frames since entering the current scene, registered.
- `scene_start`, output, 1: one-`Clk` pulse in the first cycle a new `status` is visible.

## Operation
Status codes:
- 0 TITLE
- 2 ROOM
- 3 BATTLE_MENU
- 4 BATTLE_DODGE
- 5 FLOWER
- 6 GAMEOVER
- 7 WIN
- Codes 1 and 8–15 are unused. If `status` ever holds one of them, the next state is TITLE.

Frame tick:
- `frame_clk` passes through a 2-flop synchroniser, then a 3rd flop for edge detection.
- `tick` = synchronised level AND NOT delayed level.
- `tick` is high for exactly one `Clk` per `frame_clk` rising edge.

Confirm press:
- `confirm` = (`keycode` == CONFIRM_KEY) AND (previous-cycle `keycode` != CONFIRM_KEY).
- Holding the key produces a single press.

Transitions (evaluated every `Clk`):
- TITLE → ROOM on `confirm`.
- ROOM → FLOWER when `encounter` is high.
- FLOWER → BATTLE_MENU on the `tick` where `frame_cnt` == FLOWER_FRAMES−1.
- BATTLE_MENU → BATTLE_DODGE on `confirm`.
- BATTLE_DODGE, in priority order:
  - `player_hp` == 0 → GAMEOVER.
  - else `dodge_done` and `enemy_defeated` → WIN.
  - else `dodge_done` → BATTLE_MENU.
- GAMEOVER → TITLE on `confirm`, but only when `frame_cnt` ≥ GAMEOVER_LOCK.
- WIN → TITLE on `confirm`.

Frame counter:
- Cleared to 0 on every transition.
- Otherwise increments on `tick`.
- Saturates at 4095; it never wraps.
- If a transition and a `tick` occur in the same cycle, the clear wins.

`scene_start`:
- Registered.
- High in the cycle after any transition edge, i.e. the same cycle the new `status` first appears.

## Timing
- Reset values: `status` = 0, `frame_cnt` = 0, `scene_start` = 0; synchroniser flops = 0; previous-keycode register = 0.
- Reset release alone never produces a `tick` or a `confirm`.
- `frame_clk` rise to `tick`: 2–3 `Clk`, depending on phase.
- Condition to output: if a condition is true in cycle N, `status`, `frame_cnt` = 0 and `scene_start` = 1 are all visible in cycle N+1.
- FLOWER duration: exactly FLOWER_FRAMES ticks from entry. `frame_cnt` reads 0…FLOWER_FRAMES−1 while `status` == 5.
- Reset asserted mid-scene: all outputs return to their reset values immediately (asynchronous). A key held through reset release does not count as a press until it is released and pressed again.
- `encounter` held high: it only matters while in ROOM. After FLOWER ends, it does not re-trigger a transition.

## Structure
- Package `scene_pkg`:
  - `status_t` enum (4-bit) holding the seven codes above.
  - Key-code constants.
  - The package is shared with the sprite stages and the color mapper so they compare against `status_t` names.
- Sub-module `frame_tick_sync`:
  - 2-flop synchroniser plus edge detector.
  - Inputs: `Clk`, `Reset`, `frame_clk`. Output: `tick`.
  - Reused by any block that needs frame-rate events in the `Clk` domain.
- The remainder of the block is one FSM register with its next-state logic, the frame counter, and the previous-keycode register.

## Test plan
- Reset, then a `keycode` 0→0x28 press → `status` 0→2 one `Clk` later with `scene_start` = 1 for 1 cycle. Holding 0x28 for 100 cycles causes no further change.
- In ROOM, pulse `encounter` → `status` = 5, then apply 360 `frame_clk` edges → `status` = 3 exactly on tick 360. `frame_cnt` reaches 359 while `status` == 5.
- In BATTLE_DODGE, drive `player_hp` = 0 and `dodge_done` = 1 in the same cycle → `status` = 6, not 3 or 7.
- In GAMEOVER, press confirm at `frame_cnt` = 30 → no change. Press again at `frame_cnt` = 60 → `status` = 0.
- Assert `Reset` mid-FLOWER at `frame_cnt` = 200 → `status`, `frame_cnt` and `scene_start` are all 0 immediately. No `tick` or `confirm` occurs on release.
- In FLOWER, align a `tick` with the exit transition, and drive 5000 ticks while in WIN → `frame_cnt` = 0 after the transition; `frame_cnt` saturates at 4095 in WIN.
